pixel_readout_ctrl: RTL and testbench
=====================================

# pixel_readout_ctrl

Sequencer sitting directly downstream of the root of the pixel priority-encoder tree. It watches the tree's `VALID`, drives the root address-enable and the sync/clear clock (`CLKIN`), captures the winning pixel address, and tags it with a free-running timestamp. It queues each hit in a small FIFO and presents it on a ready/valid output stream. One hit is drained per transaction, highest-priority pixel first, until the tree reports no pending hits.

## Interface
- `WID`, 8: pixel address width from the tree root; the tree covers 2^WID pixels.
- `TS_WID`, 8: timestamp counter width.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `SETTLE`, 2: cycles `ADDREN` is held before capture so the tree address ripples through; must be at least 1.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RSTN`  in  1  asynchronous, active-low reset.
- `RD_EN`  in  1  readout enable; new transactions start only while high.
- `VALID`  in  1  OR of all pending hits, from the tree root.
- `ADDR`  in  WID  winning pixel address from the tree root.
- `ADDREN`  out  1  address enable into the tree root (`ADDREI`).
- `CLKIN`  out  1  sync/clear pulse into the tree root; clears the selected pixel.
- `DOUT`  out  TS_WID+WID  FIFO head, {timestamp, address}.
- `DOUT_VALID`  out  1  FIFO not empty.
- `DOUT_READY`  in  1  consumer accepts `DOUT` when both are high.
- `FIFO_CNT`  out  log2(DEPTH)+1  current FIFO occupancy.
- `BUSY`  out  1  FSM not in IDLE.

## Operation
- FSM states:
  - IDLE: `ADDREN`=0, `CLKIN`=0. Moves to ENABLE when `RD_EN` & `VALID` & (`FIFO_CNT` < `DEPTH`) are all true at the edge; otherwise stays in IDLE.
  - ENABLE: `ADDREN`=1. Held for exactly SETTLE cycles, tracked by a down-counter loaded on entry. If `VALID` is sampled low in any ENABLE cycle, the FSM aborts to RECOVER.
  - CAPTURE: `ADDREN`=1, held for one cycle. If `VALID` is high at the edge, {ts, `ADDR`} is written to the FIFO and the FSM moves to PULSE. If `VALID` is low, nothing is written and the FSM moves to RECOVER.
  - PULSE: `ADDREN`=1, `CLKIN`=1, held for one cycle, then RECOVER.
  - RECOVER: `ADDREN`=0, `CLKIN`=0, held for one cycle so the cleared pixel state can settle. Always returns to IDLE.
- `ADDREN` and `CLKIN` come straight from flops (decoded from the next state) and never glitch. `CLKIN` is never high unless `ADDREN` is also high.
- Timestamp: a TS_WID counter increments every cycle and wraps from 2^TS_WID-1 to 0. The value stored is the counter value at the CAPTURE edge.
- FIFO:
  - A write only occurs from a transaction that was admitted with a free slot, so overflow is impossible.
  - A pop happens on `DOUT_VALID` & `DOUT_READY`.
  - A simultaneous push and pop leaves `FIFO_CNT` unchanged and preserves ordering.
  - Pointers wrap modulo DEPTH.
- If `RD_EN` falls mid-transaction, the transaction completes and the FSM then holds in IDLE.
- If `VALID` is high while the FIFO is full, the FSM holds in IDLE. No hit is lost; it stays pending in the pixel.

## Timing
- Reset (`RSTN` low, asynchronous): FSM goes to IDLE, and `ADDREN`, `CLKIN`, `BUSY`, `DOUT_VALID` all go to 0. `FIFO_CNT`, the pointers and the timestamp reset to 0. `DOUT` reads as 0. This takes effect immediately, including mid-PULSE.
- Sequence for one hit, with edge E0 being the IDLE edge that sees `VALID`:
  - `ADDREN` rises after E0.
  - CAPTURE ends at edge E(SETTLE+1).
  - `CLKIN` is high between E(SETTLE+1) and E(SETTLE+2).
  - `ADDREN` falls after E(SETTLE+2).
  - The FSM is back in IDLE after E(SETTLE+3).
  - Minimum spacing between `CLKIN` pulses is SETTLE+4 cycles (6 with the default SETTLE).
- `DOUT_VALID` rises in the cycle after the CAPTURE edge; the write-to-read latency is 1 cycle.
- `DOUT` changes only on a pop edge, or on a write into an empty FIFO.

## Test plan
- Three hits at 0x05, 0xA3 and 0x42 (tree model, lowest address wins), `DOUT_READY`=1: three `CLKIN` pulses spaced exactly 6 cycles apart; `DOUT` addresses appear in order 0x05, 0x42, 0xA3; timestamps increase by 6 between hits; `VALID` ends low and `BUSY`=0.
- `DOUT_READY`=0 with 5 pending hits: exactly 4 writes, `FIFO_CNT`=4, and the FSM holds in IDLE with `ADDREN`=0. Raising `DOUT_READY` for one cycle pops 1 entry, after which the 5th hit is read; final `FIFO_CNT`=4.
- Timestamp wrap: a hit captured with ts=0xFF followed by a hit 6 cycles later gives timestamps 0xFF then 0x05.
- `VALID` dropped during ENABLE: no FIFO write and no `CLKIN` pulse; `ADDREN` falls; the FSM is back in IDLE 2 cycles after the abort edge.
- `RSTN` asserted mid-PULSE with 2 entries queued: `CLKIN` and `ADDREN` drop without waiting for a clock edge; after release `FIFO_CNT`=0, `DOUT_VALID`=0 and ts=0, and the next hit is read normally.
- `RD_EN` falls during ENABLE: the current hit completes (one `CLKIN`, one write), then no new transaction starts while `VALID` stays high.

Source files
------------

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl
// Drains hits from the root of a pixel priority-encoder tree one at a time:
// enables the root address, lets it settle, captures {timestamp, address}
// into a small FIFO, then pulses CLKIN to clear the winning pixel. The FIFO
// head is presented as a ready/valid stream.
module pixel_readout_ctrl #(
    parameter int WID    = 8,
    parameter int TS_WID = 8,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   RD_EN,
    input  logic                   VALID,
    input  logic [WID-1:0]         ADDR,
    output logic                   ADDREN,
    output logic                   CLKIN,
    output logic [TS_WID+WID-1:0]  DOUT,
    output logic                   DOUT_VALID,
    input  logic                   DOUT_READY,
    output logic [$clog2(DEPTH):0] FIFO_CNT,
    output logic                   BUSY
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DW  = TS_WID + WID;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENABLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_PULSE   = 3'd3,
        S_RECOVER = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [SCW-1:0]    settle_q, settle_d;
    logic              addren_q, clkin_q, busy_q;
    logic [TS_WID-1:0] ts_q;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push       = (state_q == S_CAPTURE) && VALID;
    assign pop        = !fifo_empty && DOUT_READY;

    // Next-state decode for the readout sequence.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE: begin
                if (RD_EN && VALID && !fifo_full) begin
                    state_d  = S_ENABLE;
                    settle_d = SCW'(SETTLE - 1);
                end
            end
            S_ENABLE: begin
                if (!VALID) begin
                    state_d = S_RECOVER;
                end else if (settle_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q - SCW'(1);
                end
            end
            S_CAPTURE: state_d = VALID ? S_PULSE : S_RECOVER;
            S_PULSE:   state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM state plus glitch-free tree controls decoded from the next state.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            addren_q <= 1'b0;
            clkin_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            addren_q <= (state_d == S_ENABLE) || (state_d == S_CAPTURE) || (state_d == S_PULSE);
            clkin_q  <= (state_d == S_PULSE);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    // Free-running timestamp, wraps naturally at 2^TS_WID.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WID'(1);
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // FIFO pointers and count; pointers wrap modulo DEPTH.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // FIFO storage: {timestamp at the capture edge, winning address}.
    // NOTE: the storage array has no reset; occupancy gates every read, so stale contents are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, ADDR};
        end
    end

    assign DOUT       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign DOUT_VALID = !fifo_empty;
    assign FIFO_CNT   = cnt_q;
    assign ADDREN     = addren_q;
    assign CLKIN      = clkin_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb_pixel_readout_ctrl
// Drives pixel_readout_ctrl from a behavioural priority-encoder tree model
// (pending bitmap, lowest address wins, CLKIN clears the selected pixel) and
// compares the output stream against the hits the model says were read.
module tb_pixel_readout_ctrl;

    localparam int WID     = 8;
    localparam int TS_WID  = 8;
    localparam int DEPTH   = 4;
    localparam int SETTLE  = 2;
    localparam int DW      = TS_WID + WID;
    localparam int NPIX    = 2 ** WID;
    localparam int SPACING = SETTLE + 4;

    logic                   CLK = 1'b0;
    logic                   RSTN = 1'b1;
    logic                   RD_EN = 1'b0;
    logic                   VALID = 1'b0;
    logic [WID-1:0]         ADDR = '0;
    logic                   DOUT_READY = 1'b0;
    logic                   ADDREN, CLKIN, DOUT_VALID, BUSY;
    logic [DW-1:0]          DOUT;
    logic [$clog2(DEPTH):0] FIFO_CNT;

    int checks = 0;
    int errors = 0;

    logic [NPIX-1:0] pending = '0;
    int              cur_addr = 0;
    int              n_inj = 0;
    int              cyc;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   obs_q[$];
    int              pulse_cyc_q[$];

    pixel_readout_ctrl #(
        .WID(WID), .TS_WID(TS_WID), .DEPTH(DEPTH), .SETTLE(SETTLE)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .RD_EN(RD_EN), .VALID(VALID), .ADDR(ADDR),
        .ADDREN(ADDREN), .CLKIN(CLKIN), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .FIFO_CNT(FIFO_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Cycles since reset release; equals the timestamp counter by definition.
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Tree root: VALID is the OR of pending pixels, ADDR the lowest pending one.
    task automatic drive_tree();
        cur_addr = 0;
        VALID    = 1'b0;
        for (int i = NPIX - 1; i >= 0; i--) begin
            if (pending[i]) begin
                cur_addr = i;
                VALID    = 1'b1;
            end
        end
        ADDR = WID'(cur_addr);
    endtask

    task automatic inject(input int a);
        if (!pending[a]) n_inj++;
        pending[a] = 1'b1;
        drive_tree();
    endtask

    // One clock: record a pop at the coming edge, then at the falling edge
    // record any CLKIN pulse as a read hit and clear that pixel.
    task automatic step();
        if (RSTN && DOUT_VALID === 1'b1 && DOUT_READY) obs_q.push_back(DOUT);
        @(negedge CLK);
        if (CLKIN === 1'b1) begin
            pulse_cyc_q.push_back(cyc);
            exp_q.push_back({TS_WID'(cyc - 1), WID'(cur_addr)});
            pending[cur_addr] = 1'b0;
        end
        drive_tree();
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (pending == '0 && BUSY === 1'b0 && DOUT_VALID === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN    = 1'b0;
        pending = '0;
        drive_tree();
        exp_q.delete();
        obs_q.delete();
        pulse_cyc_q.delete();
        n_inj = 0;
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        #1 RSTN = 1'b0;
        #2;
        checks++;
        if ({ADDREN, CLKIN, BUSY, DOUT_VALID} !== 4'b0000 || FIFO_CNT !== '0 || DOUT !== '0) begin
            errors++;
            $display("FAIL reset_state: got addren=%b clkin=%b busy=%b dv=%b cnt=%0d dout=%h required all 0",
                     ADDREN, CLKIN, BUSY, DOUT_VALID, FIFO_CNT, DOUT);
        end
        @(negedge CLK);
        RSTN  = 1'b1;
        RD_EN = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (BUSY !== 1'b0 || ADDREN !== 1'b0 || FIFO_CNT !== '0) begin
            errors++;
            $display("FAIL idle_no_hits: got busy=%b addren=%b cnt=%0d required 0 0 0", BUSY, ADDREN, FIFO_CNT);
        end
    endtask

    task automatic test_sequence();
        int a;
        bit ok;
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b0;
        a = $urandom_range(0, NPIX - 1);
        inject(a);
        for (int k = 1; k <= SETTLE + 4; k++) begin
            step();
            checks++;
            if (ADDREN !== (k <= SETTLE + 2) || CLKIN !== (k == SETTLE + 2) ||
                BUSY !== (k <= SETTLE + 3) || DOUT_VALID !== (k >= SETTLE + 2)) begin
                errors++;
                $display("FAIL sequence_cycle%0d: got addren=%b clkin=%b busy=%b dv=%b required %b %b %b %b", k,
                         ADDREN, CLKIN, BUSY, DOUT_VALID, k <= SETTLE + 2, k == SETTLE + 2,
                         k <= SETTLE + 3, k >= SETTLE + 2);
            end
        end
        checks++;
        if (FIFO_CNT !== 1 || DOUT !== {TS_WID'(SETTLE + 1), WID'(a)}) begin
            errors++;
            $display("FAIL sequence_entry: got cnt=%0d dout=%h required cnt=1 dout=%h",
                     FIFO_CNT, DOUT, {TS_WID'(SETTLE + 1), WID'(a)});
        end
        DOUT_READY = 1'b1;
        wait_quiet(20, ok);
        checks++;
        if (!ok || obs_q.size() != 1 || FIFO_CNT !== '0 || DOUT !== '0) begin
            errors++;
            $display("FAIL sequence_pop: got ok=%0d pops=%0d cnt=%0d dout=%h required 1 1 0 0",
                     ok, obs_q.size(), FIFO_CNT, DOUT);
        end
    endtask

    task automatic test_three_hits();
        bit ok;
        logic [WID-1:0]    want [3];
        logic [TS_WID-1:0] d;
        want = '{8'h05, 8'h42, 8'hA3};
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b1;
        inject(8'h05);
        inject(8'hA3);
        inject(8'h42);
        wait_quiet(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL three_hits_timeout: got not drained required drained");
        end
        checks++;
        if (pulse_cyc_q.size() != 3) begin
            errors++;
            $display("FAIL three_hits_pulses: got %0d required 3", pulse_cyc_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (pulse_cyc_q[i] - pulse_cyc_q[i-1] != SPACING) begin
                    errors++;
                    $display("FAIL three_hits_spacing%0d: got %0d required %0d", i,
                             pulse_cyc_q[i] - pulse_cyc_q[i-1], SPACING);
                end
            end
        end
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL three_hits_count: got %0d outputs, %0d reads required 3", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i][WID-1:0] !== want[i] || obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL three_hits_entry%0d: got %h required %h (addr %h)", i, obs_q[i], exp_q[i], want[i]);
                end
                if (i > 0) begin
                    d = obs_q[i][DW-1:WID] - obs_q[i-1][DW-1:WID];
                    checks++;
                    if (d !== TS_WID'(SPACING)) begin
                        errors++;
                        $display("FAIL three_hits_ts_step%0d: got %0d required %0d", i, d, SPACING);
                    end
                end
            end
        end
        checks++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL three_hits_end: got valid=%b busy=%b required 0 0", VALID, BUSY);
        end
    endtask

    task automatic test_fifo_full();
        int addrs[$];
        int a;
        bit ok;
        bit held;
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b0;
        while (addrs.size() < 5) begin
            a = $urandom_range(0, NPIX - 1);
            if (!pending[a]) begin
                addrs.push_back(a);
                inject(a);
            end
        end
        addrs.sort();
        for (int i = 0; i < 5 * SPACING + 10; i++) step();
        checks++;
        if (pulse_cyc_q.size() != 4 || FIFO_CNT !== 4 || VALID !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: got pulses=%0d cnt=%0d valid=%b required 4 4 1",
                     pulse_cyc_q.size(), FIFO_CNT, VALID);
        end
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ADDREN !== 1'b0 || BUSY !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL full_hold_idle: got addren/busy active required idle while full");
        end
        DOUT_READY = 1'b1;
        step();
        DOUT_READY = 1'b0;
        for (int i = 0; i < 3 * SPACING; i++) step();
        checks++;
        if (pulse_cyc_q.size() != 5 || FIFO_CNT !== 4 || VALID !== 1'b0 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL full_refill: got pulses=%0d cnt=%0d valid=%b pops=%0d required 5 4 0 1",
                     pulse_cyc_q.size(), FIFO_CNT, VALID, obs_q.size());
        end
        DOUT_READY = 1'b1;
        wait_quiet(40, ok);
        checks++;
        if (!ok || obs_q.size() != 5 || exp_q.size() != 5) begin
            errors++;
            $display("FAIL full_drain: got ok=%0d outputs=%0d reads=%0d required 1 5 5", ok, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || obs_q[i][WID-1:0] !== WID'(addrs[i])) begin
                    errors++;
                    $display("FAIL full_entry%0d: got %h required %h (addr %h)", i, obs_q[i], exp_q[i], addrs[i]);
                end
            end
        end
    endtask

    task automatic test_ts_wrap();
        bit ok;
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b1;
        for (int i = 0; i < 300 && (cyc % (2 ** TS_WID)) != 8'hFC; i++) step();
        inject(8'h10);
        inject(8'h80);
        wait_quiet(60, ok);
        checks++;
        if (!ok || obs_q.size() != 2) begin
            errors++;
            $display("FAIL ts_wrap_count: got ok=%0d outputs=%0d required 1 2", ok, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {8'hFF, 8'h10} || obs_q[1] !== {8'h05, 8'h80}) begin
                errors++;
                $display("FAIL ts_wrap_values: got %h %h required ff10 0580", obs_q[0], obs_q[1]);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b1;
        inject($urandom_range(0, NPIX - 1));
        step();
        checks++;
        if (ADDREN !== 1'b1) begin
            errors++;
            $display("FAIL abort_enable: got addren=%b required 1", ADDREN);
        end
        pending = '0;
        drive_tree();
        step();
        checks++;
        if (ADDREN !== 1'b0 || CLKIN !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL abort_recover: got addren=%b clkin=%b busy=%b required 0 0 1", ADDREN, CLKIN, BUSY);
        end
        step();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b required 0", BUSY);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (pulse_cyc_q.size() != 0 || FIFO_CNT !== '0 || DOUT_VALID !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_write: got pulses=%0d cnt=%0d dv=%b pops=%0d required 0 0 0 0",
                     pulse_cyc_q.size(), FIFO_CNT, DOUT_VALID, obs_q.size());
        end
    endtask

    task automatic test_reset_mid_pulse();
        int c;
        bit ok;
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b0;
        inject(8'h21);
        inject(8'h7E);
        for (int i = 0; i < 40 && pulse_cyc_q.size() < 2; i++) step();
        checks++;
        if (CLKIN !== 1'b1 || FIFO_CNT !== 2) begin
            errors++;
            $display("FAIL midpulse_setup: got clkin=%b cnt=%0d required 1 2", CLKIN, FIFO_CNT);
        end
        RSTN = 1'b0;
        #1;
        checks++;
        if ({ADDREN, CLKIN, BUSY, DOUT_VALID} !== 4'b0000 || FIFO_CNT !== '0 || DOUT !== '0) begin
            errors++;
            $display("FAIL midpulse_async: got addren=%b clkin=%b busy=%b dv=%b cnt=%0d dout=%h required all 0",
                     ADDREN, CLKIN, BUSY, DOUT_VALID, FIFO_CNT, DOUT);
        end
        pending = '0;
        drive_tree();
        exp_q.delete();
        obs_q.delete();
        pulse_cyc_q.delete();
        @(negedge CLK);
        RSTN = 1'b1;
        c = $urandom_range(0, NPIX - 1);
        inject(c);
        DOUT_READY = 1'b1;
        wait_quiet(40, ok);
        checks++;
        if (!ok || obs_q.size() != 1 || pulse_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL midpulse_after: got ok=%0d outputs=%0d pulses=%0d required 1 1 1",
                     ok, obs_q.size(), pulse_cyc_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {TS_WID'(SETTLE + 1), WID'(c)}) begin
                errors++;
                $display("FAIL midpulse_entry: got %h required %h", obs_q[0], {TS_WID'(SETTLE + 1), WID'(c)});
            end
        end
    endtask

    task automatic test_rd_en_fall();
        bit ok;
        do_reset();
        RD_EN      = 1'b1;
        DOUT_READY = 1'b1;
        inject(8'h33);
        inject(8'hC4);
        step();
        RD_EN = 1'b0;
        for (int i = 0; i < 4 * SPACING; i++) step();
        checks++;
        if (pulse_cyc_q.size() != 1 || obs_q.size() != 1 || VALID !== 1'b1 ||
            BUSY !== 1'b0 || ADDREN !== 1'b0 || FIFO_CNT !== '0) begin
            errors++;
            $display("FAIL rden_fall_hold: got pulses=%0d pops=%0d valid=%b busy=%b addren=%b cnt=%0d required 1 1 1 0 0 0",
                     pulse_cyc_q.size(), obs_q.size(), VALID, BUSY, ADDREN, FIFO_CNT);
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0] || obs_q[0][WID-1:0] !== 8'h33) begin
                errors++;
                $display("FAIL rden_fall_entry: got %h required %h (addr 33)", obs_q[0], exp_q[0]);
            end
        end
        RD_EN = 1'b1;
        wait_quiet(40, ok);
        checks++;
        if (!ok || pulse_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL rden_resume: got ok=%0d pulses=%0d required 1 2", ok, pulse_cyc_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        bit inv_ok;
        int min_gap;
        do_reset();
        inv_ok = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) inject($urandom_range(0, NPIX - 1));
            DOUT_READY = ($urandom_range(0, 3) != 0);
            RD_EN      = ($urandom_range(0, 7) != 0);
            step();
            if ((CLKIN === 1'b1 && ADDREN !== 1'b1) || FIFO_CNT > DEPTH) inv_ok = 1'b0;
        end
        RD_EN      = 1'b1;
        DOUT_READY = 1'b1;
        wait_quiet(600, ok);
        checks++;
        if (!ok || !inv_ok) begin
            errors++;
            $display("FAIL random_run: got drained=%0d invariants=%0d required 1 1", ok, inv_ok);
        end
        checks++;
        if (obs_q.size() != n_inj || exp_q.size() != n_inj) begin
            errors++;
            $display("FAIL random_count: got outputs=%0d reads=%0d required %0d", obs_q.size(), exp_q.size(), n_inj);
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_entry%0d: got %h required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        min_gap = SPACING;
        for (int i = 1; i < pulse_cyc_q.size(); i++) begin
            if (pulse_cyc_q[i] - pulse_cyc_q[i-1] < min_gap) min_gap = pulse_cyc_q[i] - pulse_cyc_q[i-1];
        end
        checks++;
        if (min_gap < SPACING) begin
            errors++;
            $display("FAIL random_spacing: got min gap %0d required >= %0d", min_gap, SPACING);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_three_hits();
        test_fifo_full();
        test_ts_wrap();
        test_abort();
        test_reset_mid_pulse();
        test_rd_en_fall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
